// File: rtl/cpu_reg_pkg.sv
// Shared types for the APB configuration register file: word type, bus phase
// states and the register-kind decode helper.
package cpu_reg_pkg;

  localparam int REG_W = 32;
  localparam int IDX_W = 8;

  typedef logic [REG_W-1:0] reg_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } apb_state_e;

  typedef enum logic [1:0] {
    RW,
    STS,
    RO,
    BAD
  } reg_kind_e;

  // Word index map: RW block first, then sticky status, then read-only.
  function automatic reg_kind_e reg_kind(input logic [IDX_W-1:0] idx,
                                         input int num_rw,
                                         input int num_sts,
                                         input int num_ro);
    int i;
    i = int'(idx);
    if (i < num_rw) return RW;
    if (i < num_rw + num_sts) return STS;
    if (i < num_rw + num_sts + num_ro) return RO;
    return BAD;
  endfunction

endpackage

// File: rtl/apb_slv_fsm.sv
// APB3 slave phase tracker: latches the setup-phase request, inserts wait
// states and raises a one-cycle commit as the transfer enters DONE.
module apb_slv_fsm
  import cpu_reg_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_psel,
  input  logic             i_penable,
  input  logic             i_pwrite,
  input  logic [31:0]      i_paddr,
  input  reg_word_t        i_pwdata,
  output logic             o_commit,
  output logic [IDX_W-1:0] o_idx,
  output reg_word_t        o_wdata,
  output logic             o_write,
  output logic             o_pready
);

  localparam int LAST_WAIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  apb_state_e       state, state_nxt;
  logic [2:0]       wait_cnt, wait_cnt_nxt;
  logic             capture;
  logic             setup_ph, access_ph;
  logic [IDX_W-1:0] idx_p0;
  reg_word_t        wdata_p0;
  logic             write_p0;
  logic             unused_addr;

  assign setup_ph    = i_psel & ~i_penable;
  assign access_ph   = i_psel & i_penable;
  assign unused_addr = ^{i_paddr[31:10], i_paddr[1:0]};

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    capture      = 1'b0;
    o_commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (setup_ph) begin
          state_nxt = SETUP;
          capture   = 1'b1;
        end
      end
      SETUP: begin
        if (!access_ph) begin
          state_nxt = IDLE;
        end else if (WAIT_STATES == 0) begin
          state_nxt = DONE;
          o_commit  = 1'b1;
        end else begin
          state_nxt    = ACCESS;
          wait_cnt_nxt = '0;
        end
      end
      ACCESS: begin
        // A master dropping psel/penable before pready aborts the transfer.
        if (!access_ph) begin
          state_nxt = IDLE;
        end else if (wait_cnt == 3'(LAST_WAIT)) begin
          state_nxt = DONE;
          o_commit  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 3'd1;
        end
      end
      DONE: begin
        if (setup_ph) begin
          state_nxt = SETUP;
          capture   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Setup-phase capture (data path, no reset)
  always_ff @(posedge i_clk) begin
    if (capture) begin
      idx_p0   <= i_paddr[9:2];
      wdata_p0 <= i_pwdata;
      write_p0 <= i_pwrite;
    end
  end

  assign o_idx    = idx_p0;
  assign o_wdata  = wdata_p0;
  assign o_write  = write_p0;
  assign o_pready = (state == DONE);

endmodule

// File: rtl/apb_cfg_regfile.sv
// APB3 configuration/status register file: RW config registers with strobes,
// hardware-set W1C sticky status with registered irq, and sampled RO words.
module apb_cfg_regfile
  import cpu_reg_pkg::*;
#(
  parameter int                     NUM_RW      = 8,
  parameter int                     NUM_STS     = 2,
  parameter int                     NUM_RO      = 2,
  parameter int                     WAIT_STATES = 0,
  parameter reg_word_t [NUM_RW-1:0] RST_VAL     = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_psel,
  input  logic                       i_penable,
  input  logic                       i_pwrite,
  input  logic [31:0]                i_paddr,
  input  reg_word_t                  i_pwdata,
  output reg_word_t                  o_prdata,
  output logic                       o_pready,
  output logic                       o_pslverr,
  output reg_word_t [NUM_RW-1:0]     c_rw,
  output logic [NUM_RW-1:0]          o_wr_stb,
  input  reg_word_t [NUM_STS-1:0]    i_sts_set,
  output reg_word_t [NUM_STS-1:0]    c_sts,
  output logic                       o_irq,
  input  reg_word_t [NUM_RO-1:0]     i_ro
);

  logic                    commit;
  logic                    write;
  logic [IDX_W-1:0]        idx;
  reg_word_t               wdata;
  reg_kind_e               kind;
  reg_word_t               rd_val;
  logic                    wr_rw, wr_sts;
  reg_word_t [NUM_STS-1:0] sts_nxt;

  apb_slv_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_psel   (i_psel),
    .i_penable(i_penable),
    .i_pwrite (i_pwrite),
    .i_paddr  (i_paddr),
    .i_pwdata (i_pwdata),
    .o_commit (commit),
    .o_idx    (idx),
    .o_wdata  (wdata),
    .o_write  (write),
    .o_pready (o_pready)
  );

  assign kind   = reg_kind(idx, NUM_RW, NUM_STS, NUM_RO);
  assign wr_rw  = commit & write & (kind == RW);
  assign wr_sts = commit & write & (kind == STS);

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_RW; k++)
      if (idx == IDX_W'(k)) rd_val = c_rw[k];
    for (int j = 0; j < NUM_STS; j++)
      if (idx == IDX_W'(NUM_RW + j)) rd_val = c_sts[j];
    for (int r = 0; r < NUM_RO; r++)
      if (idx == IDX_W'(NUM_RW + NUM_STS + r)) rd_val = i_ro[r];
  end

  // Hardware set is ORed in after the software clear so it always wins.
  always_comb begin
    sts_nxt = '0;
    for (int j = 0; j < NUM_STS; j++) begin
      sts_nxt[j] = c_sts[j] | i_sts_set[j];
      if (wr_sts && idx == IDX_W'(NUM_RW + j))
        sts_nxt[j] = (c_sts[j] & ~wdata) | i_sts_set[j];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      c_rw     <= RST_VAL;
      o_wr_stb <= '0;
    end else begin
      o_wr_stb <= '0;
      for (int k = 0; k < NUM_RW; k++) begin
        if (wr_rw && idx == IDX_W'(k)) begin
          c_rw[k]     <= wdata;
          o_wr_stb[k] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      c_sts <= '0;
      o_irq <= 1'b0;
    end else begin
      c_sts <= sts_nxt;
      o_irq <= |c_sts;
    end
  end

  // Response registers: only meaningful in DONE, zero otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_prdata  <= '0;
      o_pslverr <= 1'b0;
    end else begin
      o_prdata  <= '0;
      o_pslverr <= 1'b0;
      if (commit) begin
        if (write) begin
          o_pslverr <= (kind == RO) || (kind == BAD);
        end else begin
          o_prdata  <= rd_val;
          o_pslverr <= (kind == BAD);
        end
      end
    end
  end

endmodule
